hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard controller that drives the stall, freeze and flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage MIPS core. It detects load-use hazards against the instruction held in ID/EX, and redirects on taken branches and jumps resolved in EX. It also freezes the whole pipeline while the data memory is busy, with a watchdog that latches a sticky error on timeout.

## Interface
- `WAIT_TIMEOUT`, 64: maximum consecutive MEM_WAIT cycles before the ERROR state (legal range 2..65535).
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads rt as a source (R-type, beq, sw).
- `ex_rt`  in  5  rt of the instruction in ID/EX (load destination).
- `ex_mem_read`  in  1  ID/EX holds a load.
- `ex_branch`, `ex_zero`, `ex_jump`  in  1 each  branch control, ALU zero, jump control in EX.
- `mem_access`  in  1  EX/MEM holds a load or store.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`  out  1 each  register enables.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble (all-zero controls) on the next edge.
- `pc_redirect`  out  1  PC selects the branch or jump target.
- `mem_timeout_error`  out  1  sticky watchdog flag.

## Operation
- States: RUN, MEM_WAIT, ERROR. Wait counter `wait_cnt` is 16 bits.
- Defaults: all enables = 1, all flushes = 0, `pc_redirect` = 0.
- Priority per cycle: freeze > redirect > load-use.
- Freeze is asserted when (RUN and `mem_access` and !`mem_ready`), in MEM_WAIT while !`mem_ready`, and always in ERROR.
  - During freeze all four enables = 0, all flushes = 0, `pc_redirect` = 0.
  - Redirect and load-use are suppressed; they re-evaluate once the freeze lifts.
- Redirect: `taken` = (`ex_branch` and `ex_zero`) or `ex_jump`.
  - Sets `pc_redirect` = 1, `if_id_flush` = 1 and `id_ex_flush` = 1; enables stay 1.
  - Load-use is ignored because the ID instruction is wrong-path.
- Load-use: `ex_mem_read` and `ex_rt` != 0 and (`ex_rt` == `id_rs` or (`id_uses_rt` and `ex_rt` == `id_rt`)).
  - Sets `pc_write` = 0, `if_id_write` = 0, `id_ex_flush` = 1; `id_ex_write` and `ex_mem_write` stay 1.
  - Exactly one bubble is inserted, since the bubble clears `ex_mem_read` on the next cycle.
- Register $0 never causes a stall.
- Transitions:
  - RUN -> MEM_WAIT on `mem_access` and !`mem_ready`; `wait_cnt` <= 1.
  - MEM_WAIT -> RUN on `mem_ready`; `wait_cnt` <= 0. In that cycle freeze is deasserted and normal rules apply.
  - MEM_WAIT with !`mem_ready` and `wait_cnt` == WAIT_TIMEOUT-1 -> ERROR; `mem_timeout_error` <= 1.
  - Otherwise MEM_WAIT increments `wait_cnt`.
  - ERROR is held until reset. `mem_ready` arriving in ERROR is ignored.

## Timing
- All control outputs are combinational from state and inputs within the same cycle: zero-cycle hazard response.
- The state, `wait_cnt` and error flag are registered.
- While `reset_n` = 0, asynchronously:
  - state = RUN, `wait_cnt` = 0, `mem_timeout_error` = 0.
  - Outputs forced to `pc_write` = `if_id_write` = `id_ex_write` = `ex_mem_write` = 0, `if_id_flush` = `id_ex_flush` = 1, `pc_redirect` = 0.
- First rising edge after `reset_n` rises: normal RUN behaviour.
- Reset asserted mid-MEM_WAIT or in ERROR: immediate return to the reset values above. Pending accesses are abandoned.
- A memory stall of N cycles (N < WAIT_TIMEOUT) freezes the pipeline for exactly N cycles. A 0-cycle access (`mem_ready` with `mem_access`) never freezes.
- Timeout: ERROR is entered on the edge ending the WAIT_TIMEOUT-th consecutive not-ready cycle, counting the RUN cycle that detected it.

## Configuration
- `HAZARD_PERF_COUNTERS_EN` defined adds three outputs, each 32 bits wide:
  - `stall_count`: load-use cycles.
  - `flush_count`: redirect cycles.
  - `freeze_count`: freeze cycles.
  - Each increments by 1 per qualifying cycle, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: no counters, no extra ports, and behaviour is otherwise identical.

## Test plan
- Load-use: `ex_mem_read` = 1, `ex_rt` = 5, `id_rs` = 5 -> `pc_write` = 0, `if_id_write` = 0, `id_ex_flush` = 1 for one cycle. Same with `ex_rt` = 0 -> no stall. `ex_rt` = 5, `id_rt` = 5, `id_uses_rt` = 0 -> no stall.
- Redirect: `ex_branch` = 1, `ex_zero` = 1 together with a load-use match -> `pc_redirect` = 1, both flushes = 1, `pc_write` = 1. Then `ex_branch` = 1, `ex_zero` = 0 -> defaults.
- Memory wait: `mem_access` = 1 with `mem_ready` low for 3 cycles, then high -> all enables 0 for exactly 3 cycles, enables 1 in the ready cycle, state back to RUN.
- Freeze priority: during MEM_WAIT assert `ex_jump` = 1 -> `pc_redirect` = 0 and flushes = 0 until `mem_ready`, then the redirect fires in the ready cycle.
- Watchdog: WAIT_TIMEOUT = 4, `mem_ready` held low -> `mem_timeout_error` = 1 after 4 cycles, freeze persists despite a later `mem_ready` = 1. `reset_n` pulse -> flag 0, state RUN.
- Reset mid-operation, plus counters when `HAZARD_PERF_COUNTERS_EN` is defined:
  - Drop `reset_n` during MEM_WAIT -> outputs go to reset values without a clock edge.
  - Scenarios 1–3 run after reset -> `stall_count` = 1, `flush_count` = 1, `freeze_count` = 3.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Purpose : stall/flush/freeze control for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Latency : zero-cycle; every control output is combinational from state and inputs.
// Backpres: a busy data memory freezes every stage; a watchdog latches a sticky error.
//
// Ports:
//   clk, reset_n                      clock and asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt          source registers of the ID instruction
//   ex_rt, ex_mem_read                destination and load flag of the ID/EX instruction
//   ex_branch, ex_zero, ex_jump       branch/jump resolution in EX
//   mem_access, mem_ready             data-memory handshake for the EX/MEM instruction
//   pc_write .. ex_mem_write          pipeline register enables
//   if_id_flush, id_ex_flush          bubble insertion
//   pc_redirect                       PC takes the branch/jump target
//   mem_timeout_error                 sticky watchdog flag
// Optional: define HAZARD_PERF_COUNTERS_EN to add stall_count, flush_count and
//           freeze_count (32-bit saturating event counters).

module hazard_control_unit #(
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic        ex_jump,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pc_redirect,
  output logic        mem_timeout_error
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] freeze_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0] LAST_WAIT = 16'(WAIT_TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;

  logic freeze;
  logic taken;
  logic load_use;

  // Freeze covers the RUN cycle that first sees a not-ready access, so an
  // N-cycle memory stall freezes for exactly N cycles.
  always_comb begin
    freeze = 1'b0;
    case (state)
      RUN:      freeze = mem_access && !mem_ready;
      MEM_WAIT: freeze = !mem_ready;
      ERROR:    freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
  end

  assign taken = (ex_branch && ex_zero) || ex_jump;

  // $0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Priority: freeze > redirect > load-use. A redirect ignores load-use
  // because the ID instruction is wrong-path and is flushed anyway.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pc_redirect  = 1'b0;
    if (!reset_n) begin
      // Hold the pipeline still and full of bubbles while in reset.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (taken) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      // The bubble clears ex_mem_read next cycle, so this self-limits to one cycle.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // wait_cnt counts not-ready cycles of the current access, including the
  // RUN cycle that detected it; ERROR is entered on the WAIT_TIMEOUT-th one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= RUN;
      wait_cnt          <= 16'd0;
      mem_timeout_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_access && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
          end else if (wait_cnt == LAST_WAIT) begin
            state             <= ERROR;
            mem_timeout_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ERROR: begin
          // Only reset leaves ERROR; a late mem_ready is ignored.
          state <= ERROR;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 16'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  // Each counter tracks the event that actually wins the priority this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count  <= 32'd0;
      flush_count  <= 32'd0;
      freeze_count <= 32'd0;
    end else begin
      if (freeze) begin
        if (freeze_count != 32'hFFFF_FFFF) freeze_count <= freeze_count + 32'd1;
      end else if (taken) begin
        if (flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
      end else if (load_use) begin
        if (stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose : self-checking bench for hazard_control_unit against a cycle-level model.
// Latency : outputs are checked one time unit after each falling edge.
// Backpres: memory stalls and watchdog timeouts are driven directly on mem_ready.

module tb_hazard_control_unit;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch, ex_zero, ex_jump;
  logic       mem_access, mem_ready;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic       if_id_flush, id_ex_flush, pc_redirect, mem_timeout_error;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_count, flush_count, freeze_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: consecutive not-ready cycles of the current access, and the error flag.
  int          m_nr;
  bit          m_err;
  longint      m_stall, m_flush, m_freeze;

  always #5 clk = ~clk;

  hazard_control_unit #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_jump(ex_jump),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_redirect(pc_redirect), .mem_timeout_error(mem_timeout_error)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stall_count(stall_count), .flush_count(flush_count), .freeze_count(freeze_count)
`endif
  );

  function automatic bit m_frozen();
    return m_err || (!mem_ready && (m_nr > 0 || mem_access));
  endfunction

  function automatic bit m_taken();
    return (ex_branch && ex_zero) || ex_jump;
  endfunction

  function automatic bit m_lu();
    return ex_mem_read && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  // Order: {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, pc_redirect}
  function automatic logic [6:0] m_ctrl();
    if (!reset_n)   return 7'b0000_110;
    if (m_frozen()) return 7'b0000_000;
    if (m_taken())  return 7'b1111_111;
    if (m_lu())     return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  function automatic longint sat(input longint v);
    return (v >= 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v + 1;
  endfunction

  task automatic model_reset();
    m_nr = 0; m_err = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
  endtask

  // Checks the current cycle, then lets one clock edge pass and updates the model.
  // Returns just after the next falling edge, ready for new inputs.
  task automatic step(input string tag);
    logic [6:0] obs, exp_c;
    #1;
    obs   = {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, pc_redirect};
    exp_c = m_ctrl();
    n_assert++;
    assert (obs === exp_c) else begin
      n_fail++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, exp_c);
    end
    n_assert++;
    assert (mem_timeout_error === m_err) else begin
      n_fail++;
      $error("FAIL %s err observed=%b expected=%b", tag, mem_timeout_error, m_err);
    end
`ifdef HAZARD_PERF_COUNTERS_EN
    n_assert++;
    assert ({stall_count, flush_count, freeze_count} === {m_stall[31:0], m_flush[31:0], m_freeze[31:0]}) else begin
      n_fail++;
      $error("FAIL %s counters observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
             stall_count, flush_count, freeze_count, m_stall, m_flush, m_freeze);
    end
`endif
    @(posedge clk);
    if (reset_n) begin
      if (m_frozen())     m_freeze = sat(m_freeze);
      else if (m_taken()) m_flush  = sat(m_flush);
      else if (m_lu())    m_stall  = sat(m_stall);
      if (!m_err) begin
        if (m_frozen()) begin
          m_nr++;
          if (m_nr >= TO) m_err = 1;
        end else begin
          m_nr = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0; ex_mem_read = 0;
    ex_branch = 0; ex_zero = 0; ex_jump = 0; mem_access = 0; mem_ready = 1;
  endtask

  task automatic set_lu(input logic rd, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic use_rt);
    ex_mem_read = rd; ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = use_rt;
  endtask

  initial begin
    quiet();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    step("reset_hold");
    reset_n = 1'b1;
    step("idle_after_reset");

    // Load-use
    set_lu(1, 5'd5, 5'd5, 5'd0, 0);  step("lu_rs_match");
    set_lu(0, 5'd5, 5'd5, 5'd0, 0);  step("lu_bubble_clears");
    set_lu(1, 5'd0, 5'd0, 5'd0, 1);  step("lu_reg0");
    set_lu(1, 5'd5, 5'd0, 5'd5, 0);  step("lu_rt_unused");
    set_lu(1, 5'd5, 5'd0, 5'd5, 1);  step("lu_rt_used");
    set_lu(1, 5'd7, 5'd6, 5'd8, 1);  step("lu_no_match");

    // Redirect over load-use, then untaken branch
    set_lu(1, 5'd5, 5'd5, 5'd0, 0);
    ex_branch = 1; ex_zero = 1;      step("redirect_over_lu");
    set_lu(0, 5'd0, 5'd0, 5'd0, 0);
    ex_zero = 0;                     step("branch_not_taken");
    quiet();

    // Memory wait of 3 cycles
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step($sformatf("mem_wait_%0d", i));
    mem_ready = 1;                   step("mem_ready_cycle");
    mem_access = 0;                  step("mem_back_to_run");

    // Freeze beats redirect; redirect fires in the ready cycle
    mem_access = 1; mem_ready = 0; ex_jump = 1;
    for (int i = 0; i < 2; i++) step($sformatf("freeze_over_jump_%0d", i));
    mem_ready = 1;                   step("jump_in_ready_cycle");
    quiet();                         step("after_jump");

    // Watchdog
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) step($sformatf("watchdog_%0d", i));
    mem_ready = 1;                   step("error_ignores_ready");
    mem_access = 0;                  step("error_sticky");
    reset_n = 0; model_reset();      step("reset_clears_error");
    reset_n = 1;                     step("run_after_error_reset");

    // Reset dropped mid-MEM_WAIT, checked before any clock edge
    mem_access = 1; mem_ready = 0;
    step("pre_reset_wait_0");
    step("pre_reset_wait_1");
    reset_n = 0; model_reset();      step("async_reset_mid_wait");
    quiet();
    reset_n = 1;                     step("run_after_wait_reset");

    // Randomized traffic with periodic resets
    for (int c = 0; c < 600; c++) begin
      if (c % 97 == 96) begin
        reset_n = 0; model_reset();
      end else begin
        reset_n = 1;
      end
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_branch   = ($urandom_range(0, 3) == 0);
      ex_zero     = 1'($urandom_range(0, 1));
      ex_jump     = ($urandom_range(0, 7) == 0);
      mem_access  = ($urandom_range(0, 2) == 0);
      mem_ready   = ($urandom_range(0, 2) != 0);
      step($sformatf("rand_%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
